// File: rtl/dark_count_pkg.sv
// Shared types and constants for the MPPC dark-count run sequencer,
// the dark-count counter and the top level.
package dark_count_pkg;

  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned DEF_GATE_CYCLES = 100_000_000;
  localparam int unsigned DEF_COUNT_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_GATE    = 3'd2,
    ST_LATCH   = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

endpackage

// File: rtl/dark_count_run_ctrl_gate_timer.sv
// Loadable down-counter for the measurement gate; tc is high while the
// count sits at zero.
module gate_timer #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned LENGTH = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic tc
);

  logic [WIDTH-1:0] count_q, count_d;

  // No wrap: the count parks at zero until the next load.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = WIDTH'(LENGTH - 1);
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == '0);

endmodule

// File: rtl/dark_count_run_ctrl.sv
// Run sequencer: clear counter, gate it for GATE_CYCLES, snapshot, then
// send the snapshot MSB byte first to the UART TX unit.
//
// state    | meaning
// IDLE     | waiting for a rising edge on start_uart
// CLEAR    | one-cycle counter clear
// GATE     | counter enabled for GATE_CYCLES cycles
// LATCH    | capture counter value, point at MSB byte
// SEND     | issue tx_start once TX is idle
// WAIT_TX  | wait for the byte to finish (first cycle ignored)
// DONE     | one-cycle run_done
module dark_count_run_ctrl
  import dark_count_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_uart,
  input  logic [COUNT_WIDTH-1:0] cnt_value,
  input  logic                   tx_busy,
  output logic                   cnt_clear,
  output logic                   cnt_en,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  output logic                   run_busy,
  output logic                   run_done
);

  localparam int unsigned NUM_BYTES = COUNT_WIDTH / BYTE_W;
  localparam int unsigned TIMER_W   = $clog2(GATE_CYCLES + 1);
  localparam int unsigned IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  state_e                 state_q, state_d;
  logic                   start_q, start_d;
  logic [COUNT_WIDTH-1:0] snap_q, snap_d;
  logic [IDX_W-1:0]       byte_idx_q, byte_idx_d;
  logic                   first_q, first_d;
  logic                   cnt_clear_q, cnt_clear_d;
  logic                   cnt_en_q, cnt_en_d;
  logic                   tx_start_q, tx_start_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   run_busy_q, run_busy_d;
  logic                   run_done_q, run_done_d;
  logic                   timer_load, timer_dec, timer_tc;
  logic [7:0]             byte_sel;

  gate_timer #(
    .WIDTH  (TIMER_W),
    .LENGTH (GATE_CYCLES)
  ) u_gate_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (timer_load),
    .dec   (timer_dec),
    .tc    (timer_tc)
  );

  always_comb begin
    byte_sel = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (byte_idx_q == IDX_W'(i)) byte_sel = snap_q[i*BYTE_W +: BYTE_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    start_d    = start_uart;
    snap_d     = snap_q;
    byte_idx_d = byte_idx_q;
    first_d    = first_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    run_done_d = 1'b0;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    case (state_q)
      ST_IDLE: if (start_uart && !start_q) state_d = ST_CLEAR;
      ST_CLEAR: begin
        timer_load = 1'b1;
        state_d    = ST_GATE;
      end
      ST_GATE: begin
        if (timer_tc) state_d = ST_LATCH;
        else          timer_dec = 1'b1;
      end
      ST_LATCH: begin
        snap_d     = cnt_value;
        byte_idx_d = IDX_W'(NUM_BYTES - 1);
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = byte_sel;
          first_d    = 1'b1;
          state_d    = ST_WAIT_TX;
        end
      end
      // tx_busy only rises the cycle after tx_start, so the first cycle is blind.
      ST_WAIT_TX: begin
        if (first_q) begin
          first_d = 1'b0;
        end else if (!tx_busy) begin
          if (byte_idx_q == '0) begin
            run_done_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            byte_idx_d = byte_idx_q - IDX_W'(1);
            state_d    = ST_SEND;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    cnt_clear_d = (state_d == ST_CLEAR);
    cnt_en_d    = (state_d == ST_GATE);
    run_busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b1;
      snap_q      <= '0;
      byte_idx_q  <= '0;
      first_q     <= 1'b0;
      cnt_clear_q <= 1'b0;
      cnt_en_q    <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      run_busy_q  <= 1'b0;
      run_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      snap_q      <= snap_d;
      byte_idx_q  <= byte_idx_d;
      first_q     <= first_d;
      cnt_clear_q <= cnt_clear_d;
      cnt_en_q    <= cnt_en_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      run_busy_q  <= run_busy_d;
      run_done_q  <= run_done_d;
    end
  end

  assign cnt_clear = cnt_clear_q;
  assign cnt_en    = cnt_en_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign run_busy  = run_busy_q;
  assign run_done  = run_done_q;

endmodule

// File: tb/tb_dark_count_run_ctrl.sv
// Randomized bench for dark_count_run_ctrl: counter and UART TX models drive
// the DUT; runs are checked against timing and byte expectations.
module tb_dark_count_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start_uart = 1'b0;
  logic        tx_busy = 1'b0;
  logic [31:0] cnt_value = '0;

  logic       d_clear, d_en, d_start, d_busy, d_done;
  logic [7:0] d_data;
  logic       m_clear, m_en, m_start, m_busy, m_done;
  logic [7:0] m_data;

  dark_count_run_ctrl #(.GATE_CYCLES(10), .COUNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_uart(start_uart), .cnt_value(cnt_value),
    .tx_busy(tx_busy), .cnt_clear(d_clear), .cnt_en(d_en), .tx_start(d_start),
    .tx_data(d_data), .run_busy(d_busy), .run_done(d_done));

  dark_count_run_ctrl #(.GATE_CYCLES(1), .COUNT_WIDTH(32)) dut_min (
    .clk(clk), .rst_n(rst_n), .start_uart(start_uart), .cnt_value(cnt_value),
    .tx_busy(tx_busy), .cnt_clear(m_clear), .cnt_en(m_en), .tx_start(m_start),
    .tx_data(m_data), .run_busy(m_busy), .run_done(m_done));

  always #5 clk = ~clk;

  logic       sel_min = 1'b0;
  logic       o_clear, o_en, o_start, o_busy, o_done;
  logic [7:0] o_data;
  assign o_clear = sel_min ? m_clear : d_clear;
  assign o_en    = sel_min ? m_en    : d_en;
  assign o_start = sel_min ? m_start : d_start;
  assign o_busy  = sel_min ? m_busy  : d_busy;
  assign o_done  = sel_min ? m_done  : d_done;
  assign o_data  = sel_min ? m_data  : d_data;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // run configuration
  int          g_len = 10;
  bit          use_force, inc_rand, retrig;
  logic [31:0] force_val;
  int          busy_len, fbusy;
  // models and logs
  int          cyc = 0;
  bit          model_busy, tx_arm, prev_busy, prev_en, prev_clear, junk, in_run, r1, r2;
  int          tx_rem, force_rem, start_hold;
  int          clear_cnt, clear_cyc, en_cnt, en_first, en_last, start_cnt, first_tx, done_cnt, latch_cyc;
  int          stab_err, start_busy_err, busy_err;
  logic [7:0]  cur_byte;
  logic [31:0] exp_snap;
  logic [7:0]  bytes_q[$];

  task automatic clear_logs();
    clear_cnt = 0; clear_cyc = -1; en_cnt = 0; en_first = -1; en_last = -1;
    start_cnt = 0; first_tx = -1; done_cnt = 0; latch_cyc = -1;
    stab_err = 0; start_busy_err = 0; busy_err = 0; bytes_q.delete();
  endtask

  task automatic reset_models();
    tx_busy = 1'b0; model_busy = 0; tx_arm = 0; tx_rem = 0; force_rem = 0;
    prev_busy = 0; prev_en = 0; prev_clear = 0; junk = 0; in_run = 0;
    start_hold = 0; start_uart = 1'b0; cur_byte = 8'h00;
  endtask

  // One clock: observe registered outputs, then update the models' inputs.
  task automatic step();
    @(posedge clk); #1; cyc++;
    if (o_clear) begin clear_cnt++; clear_cyc = cyc; in_run = 1; end
    if (o_en) begin en_cnt++; if (en_first < 0) en_first = cyc; en_last = cyc; end
    if (o_start) begin
      start_cnt++;
      if (first_tx < 0) first_tx = cyc;
      bytes_q.push_back(o_data);
      cur_byte = o_data;
      if (prev_busy) start_busy_err++;
    end else if (o_data !== cur_byte) stab_err++;
    if (o_busy !== in_run) busy_err++;
    if (o_done) begin done_cnt++; in_run = 0; end

    if (junk) begin cnt_value = $urandom; junk = 0; end
    if (prev_clear) cnt_value = '0;
    else if (prev_en) cnt_value += inc_rand ? 32'($urandom_range(0, 3)) : 32'd1;
    if (prev_en && !o_en) begin
      if (use_force) cnt_value = force_val;
      exp_snap = cnt_value; latch_cyc = cyc; force_rem = fbusy; junk = 1;
    end

    if (tx_arm) begin model_busy = 1; tx_rem = busy_len - 1; tx_arm = 0; end
    else if (model_busy) begin
      if (tx_rem == 0) model_busy = 0;
      else tx_rem--;
    end
    if (o_start) tx_arm = 1;
    tx_busy = model_busy || (force_rem > 0);
    if (force_rem > 0) force_rem--;
    prev_busy = tx_busy;

    if (start_hold > 0) begin
      start_hold--;
      if (start_hold == 0) start_uart = 1'b0;
    end else if (retrig && !r1 && en_cnt == 5) begin
      start_uart = 1'b1; start_hold = 1; r1 = 1;
    end else if (retrig && !r2 && start_cnt == 2 && model_busy) begin
      start_uart = 1'b1; start_hold = 1; r2 = 1;
    end
    prev_en = o_en; prev_clear = o_clear;
  endtask

  task automatic apply_reset(input string tag);
    #2; rst_n = 1'b0; #1;
    chk({tag, "/rst_outputs"}, 32'({o_clear, o_en, o_start, o_data, o_busy, o_done}), 32'h0);
    reset_models();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic run_one(input string tag, input bit uf, input logic [31:0] fv, input bit ir,
                         input int bl, input int fb, input bit rt, input int abort);
    int trig;
    bit reached;
    logic [31:0] sh;
    use_force = uf; force_val = fv; inc_rand = ir; busy_len = bl; fbusy = fb;
    retrig = rt; r1 = 0; r2 = 0; reached = 0;
    clear_logs();
    cnt_value = $urandom; exp_snap = '0;
    start_uart = 1'b0; step(); step();
    start_uart = 1'b1; start_hold = $urandom_range(1, 4); trig = cyc;
    for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
      step();
      if (abort == 1 && en_cnt == 5 && o_en) begin reached = 1; break; end
      if (abort == 2 && start_cnt == 2 && model_busy) begin reached = 1; break; end
    end
    if (abort != 0) begin
      chk({tag, "/abort_point"}, 32'(reached), 32'd1);
      apply_reset(tag);
      return;
    end
    chk({tag, "/done_seen"}, 32'(done_cnt > 0), 32'd1);
    repeat (20) step();
    chk({tag, "/clear_count"}, clear_cnt, 1);
    chk({tag, "/clear_cycle"}, clear_cyc, trig + 1);
    chk({tag, "/en_first"}, en_first, trig + 2);
    chk({tag, "/en_cycles"}, en_cnt, g_len);
    chk({tag, "/en_last"}, en_last, trig + 1 + g_len);
    chk({tag, "/first_tx_not_early"}, 32'(first_tx >= trig + 3 + g_len), 32'd1);
    if (fb > 0) chk({tag, "/tx_held_off"}, 32'(first_tx > latch_cyc + fb), 32'd1);
    chk({tag, "/tx_start_count"}, start_cnt, 4);
    for (int i = 0; i < 4; i++) begin
      sh = exp_snap >> (8 * (3 - i));
      chk($sformatf("%s/byte%0d", tag, i),
          (i < bytes_q.size()) ? {24'h0, bytes_q[i]} : 32'h100, {24'h0, sh[7:0]});
    end
    chk({tag, "/done_count"}, done_cnt, 1);
    chk({tag, "/data_stable"}, stab_err, 0);
    chk({tag, "/start_while_busy"}, start_busy_err, 0);
    chk({tag, "/run_busy"}, busy_err, 0);
  endtask

  initial begin
    reset_models();
    clear_logs();
    start_uart = 1'b1;
    #3 rst_n = 1'b0;
    #20;
    chk("por/rst_outputs", 32'({o_clear, o_en, o_start, o_data, o_busy, o_done}), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    repeat (20) step();
    chk("held_start/no_run", clear_cnt, 0);
    chk("held_start/idle", 32'(o_busy), 32'd0);

    run_one("basic",     0, 32'h0,         0, 4, 0,  0, 0);
    run_one("order",     1, 32'hDEADBEEF,  0, 4, 0,  0, 0);
    run_one("retrig",    0, 32'h0,         1, 4, 0,  1, 0);
    run_one("busy_hold", 1, 32'h8142_C3E7, 0, 4, 20, 0, 0);
    run_one("rst_gate",  0, 32'h0,         0, 4, 0,  0, 1);
    run_one("post_rst1", 1, 32'hA5C3_5A3C, 0, 4, 0,  0, 0);
    run_one("rst_byte",  1, 32'hFFEE_DDCC, 0, 4, 0,  0, 2);
    run_one("post_rst2", 0, 32'h0,         1, 4, 0,  0, 0);
    for (int k = 0; k < 6; k++) begin
      run_one($sformatf("rand%0d", k), ($urandom_range(0, 1) == 1), $urandom, 1,
              int'($urandom_range(1, 6)), ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : 0,
              0, 0);
    end

    sel_min = 1'b1; g_len = 1;
    apply_reset("min_gate");
    run_one("min_gate",  0, 32'h0,         0, 4, 0,  0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
